fft_result_streamer: RTL and testbench

//  Sits downstream of the 8-point butterfly FFT and upstream of the SPI master.

---
 rtl/fft_result_streamer.sv | 179 +++++++++++++++++
 tb/tb_fft_result_streamer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_streamer.sv
// Snapshots the 8 complex FFT bins on i_fft_valid and streams them byte-by-byte
// to an SPI master with an idle gap between bytes. Optional FFT_STREAM_HEADER_EN adds sync byte + checksum.
module fft_result_streamer #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_fft_valid,
    input  logic [16*DATA_W-1:0] i_bins,
    input  logic                 i_tx_ready,
    output logic [DATA_W-1:0]    o_tx_byte,
    output logic                 o_tx_dv,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_overrun
);

`ifdef FFT_STREAM_HEADER_EN
    localparam int NBYTES = 18;
    localparam int HDR    = 1;
`else
    localparam int NBYTES = 16;
    localparam int HDR    = 0;
`endif
    localparam int LAST   = NBYTES - 1;
    localparam int RD_W   = $clog2(NBYTES);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    // Counter runs LOAD..0, so the FSM spends exactly GAP_CYCLES cycles in GAP.
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RDY, GAP} state_t;

    logic [DATA_W-1:0] bin_bytes [16];
    logic [DATA_W-1:0] frame_buf_reg [NBYTES];

    state_t            state_reg, state_next;
    logic [4:0]        idx_reg, idx_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic              skip_reg, skip_next;
    logic [DATA_W-1:0] tx_byte_reg, tx_byte_next;
    logic              tx_dv_reg, tx_dv_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              overrun_reg, overrun_next;
    logic              capture;
    logic              advance;
    logic [RD_W-1:0]   rd_idx;
    logic              last_byte;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
            assign bin_bytes[gi] = i_bins[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign rd_idx    = idx_reg[RD_W-1:0];
    assign last_byte = (idx_reg == 5'(LAST));

`ifdef FFT_STREAM_HEADER_EN
    logic [DATA_W-1:0] bin_sum;

    always_comb begin
        bin_sum = '0;
        for (int i = 0; i < 16; i++) begin
            bin_sum = bin_sum + bin_bytes[i];
        end
    end
`endif

    // Frame buffer has no reset: its contents only matter after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < 16; i++) begin
                frame_buf_reg[i + HDR] <= bin_bytes[i];
            end
`ifdef FFT_STREAM_HEADER_EN
            frame_buf_reg[0]          <= DATA_W'(8'hA5);
            frame_buf_reg[NBYTES - 1] <= bin_sum;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            gap_reg     <= '0;
            skip_reg    <= 1'b0;
            tx_byte_reg <= '0;
            tx_dv_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            gap_reg     <= gap_next;
            skip_reg    <= skip_next;
            tx_byte_reg <= tx_byte_next;
            tx_dv_reg   <= tx_dv_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        gap_next     = gap_reg;
        skip_next    = skip_reg;
        tx_byte_next = tx_byte_reg;
        tx_dv_next   = 1'b0;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        overrun_next = i_fft_valid && (state_reg != IDLE);
        capture      = 1'b0;
        advance      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_fft_valid) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    busy_next  = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (i_tx_ready) begin
                    tx_byte_next = frame_buf_reg[rd_idx];
                    tx_dv_next   = 1'b1;
                    skip_next    = 1'b1;
                    state_next   = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                // The master deasserts ready one cycle late, so ignore it right after the strobe.
                if (skip_reg) begin
                    skip_next = 1'b0;
                end else if (i_tx_ready) begin
                    if (GAP_CYCLES > 0) begin
                        gap_next   = GAP_LOAD;
                        state_next = GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_reg == '0) begin
                    advance = 1'b1;
                end else begin
                    gap_next = gap_reg - GAP_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (advance) begin
            if (last_byte) begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end else begin
                idx_next   = idx_reg + 5'd1;
                state_next = SEND;
            end
        end
    end

    assign o_tx_byte    = tx_byte_reg;
    assign o_tx_dv      = tx_dv_reg;
    assign o_busy       = busy_reg;
    assign o_frame_done = done_reg;
    assign o_overrun    = overrun_reg;

endmodule

// File: tb/tb_fft_result_streamer.sv
// Scoreboard bench for fft_result_streamer: DUT a (GAP_CYCLES=4) and DUT b (GAP_CYCLES=0).
// Expected bytes follow the FFT_STREAM_HEADER_EN build when that macro is defined.
module tb_fft_result_streamer;
    localparam int GAP_A = 4;
    localparam int HOLD  = 20;
`ifdef FFT_STREAM_HEADER_EN
    localparam int NB = 18;
`else
    localparam int NB = 16;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_a = 1'b0, valid_b = 1'b0;
    logic [127:0] bins_a = '0, bins_b = '0;
    logic         ready_a = 1'b1;
    logic         ready_b = 1'b1;
    logic [7:0]   byte_a, byte_b;
    logic         dv_a, dv_b, busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;

    fft_result_streamer #(.DATA_W(8), .GAP_CYCLES(GAP_A)) dut_a (
        .clk(clk), .rst(rst), .i_fft_valid(valid_a), .i_bins(bins_a),
        .i_tx_ready(ready_a), .o_tx_byte(byte_a), .o_tx_dv(dv_a),
        .o_busy(busy_a), .o_frame_done(done_a), .o_overrun(ovr_a)
    );

    fft_result_streamer #(.DATA_W(8), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .i_fft_valid(valid_b), .i_bins(bins_b),
        .i_tx_ready(ready_b), .o_tx_byte(byte_b), .o_tx_dv(dv_b),
        .o_busy(busy_b), .o_frame_done(done_b), .o_overrun(ovr_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_done;
        logic [7:0] data;
        int         cyc;
    } evt_t;

    evt_t       q_a[$];
    evt_t       q_b[$];
    evt_t       ea, eb;
    logic [7:0] exp_bytes [18];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         spi_mode = 1'b0;
    int         hold_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected byte stream for one captured frame.
    task automatic build(input logic [127:0] b);
        logic [7:0] s;
        s = 8'h00;
`ifdef FFT_STREAM_HEADER_EN
        exp_bytes[0] = 8'hA5;
        for (int k = 0; k < 16; k++) begin
            exp_bytes[k + 1] = b[k*8 +: 8];
            s = s + b[k*8 +: 8];
        end
        exp_bytes[17] = s;
`else
        for (int k = 0; k < 16; k++) exp_bytes[k] = b[k*8 +: 8];
`endif
    endtask

    task automatic push_evt(input bit sel, input bit is_done, input logic [7:0] d, input int c);
        evt_t e;
        e.is_done = is_done;
        e.data    = d;
        e.cyc     = c;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
    endtask

    // Valid is asserted in cycle c; first strobe lands at c+2, then one per 'spacing',
    // and frame_done one cycle before the strobe that would follow the last byte.
    task automatic start_frame(input bit sel, input logic [127:0] b, input int spacing,
                               input int npush, input bit with_done, output int c);
        build(b);
        c = cyc;
        for (int k = 0; k < npush; k++) push_evt(sel, 1'b0, exp_bytes[k], c + 2 + k*spacing);
        if (with_done) push_evt(sel, 1'b1, 8'h00, c + 1 + NB*spacing);
        if (sel) begin bins_b = b; valid_b = 1'b1; end
        else     begin bins_a = b; valid_a = 1'b1; end
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        if (sel) chk("b_busy_after_capture", {31'd0, busy_b}, 32'd1);
        else     chk("a_busy_after_capture", {31'd0, busy_a}, 32'd1);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", q_a.size() + q_b.size(), 32'd0);
    endtask

    // SPI master model: ready drops on each strobe and returns HOLD cycles later.
    always @(negedge clk) begin
        if (spi_mode) begin
            if (dv_a === 1'b1) begin
                ready_a  = 1'b0;
                hold_cnt = HOLD;
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) ready_a = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (dv_a === 1'b1 || done_a === 1'b1) begin
            if (q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_event: got dv=%b done=%b byte=0x%02h at cycle %0d, required no event",
                         dv_a, done_a, byte_a, cyc);
            end else begin
                ea = q_a.pop_front();
                chk("a_event_kind", {31'd0, done_a}, {31'd0, ea.is_done});
                chk("a_event_cycle", cyc, ea.cyc);
                if (ea.is_done) chk("a_busy_at_done", {31'd0, busy_a}, 32'd0);
                else            chk("a_byte", {24'd0, byte_a}, {24'd0, ea.data});
                if (done_a === 1'b1) $display("[A] cycle %0d frame_done", cyc);
                else                 $display("[A] cycle %0d byte 0x%02h", cyc, byte_a);
            end
        end
    end

    always @(negedge clk) begin
        if (dv_b === 1'b1 || done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_event: got dv=%b done=%b byte=0x%02h at cycle %0d, required no event",
                         dv_b, done_b, byte_b, cyc);
            end else begin
                eb = q_b.pop_front();
                chk("b_event_kind", {31'd0, done_b}, {31'd0, eb.is_done});
                chk("b_event_cycle", cyc, eb.cyc);
                if (eb.is_done) chk("b_busy_at_done", {31'd0, busy_b}, 32'd0);
                else            chk("b_byte", {24'd0, byte_b}, {24'd0, eb.data});
                if (done_b === 1'b1) $display("[B] cycle %0d frame_done", cyc);
                else                 $display("[B] cycle %0d byte 0x%02h", cyc, byte_b);
            end
        end
    end

    initial begin
        logic [127:0] b;
        int c, c2, d;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_a_byte", {24'd0, byte_a}, 32'd0);
        chk("rst_a_dv", {31'd0, dv_a}, 32'd0);
        chk("rst_a_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_a_done", {31'd0, done_a}, 32'd0);
        chk("rst_a_overrun", {31'd0, ovr_a}, 32'd0);
        chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Bins 0x00..0x0F, ready high: strobe spacing GAP+3 = 7
        for (int k = 0; k < 16; k++) b[k*8 +: 8] = 8'(k);
        start_frame(1'b0, b, GAP_A + 3, NB, 1'b1, c);
        drain(2000);

        // SPI model: strobe at D, ready back at end of D+HOLD, GAP cycles, SEND, strobe -> HOLD+GAP+2
        spi_mode = 1'b1;
        for (int k = 0; k < 16; k++) b[k*8 +: 8] = 8'(8'h80 + k*8'h09);
        start_frame(1'b0, b, HOLD + GAP_A + 2, NB, 1'b1, c);
        drain(3000);
        spi_mode = 1'b0;
        repeat (3) @(negedge clk);

        // Overrun during byte 3, then a new frame on the frame_done cycle
        for (int k = 0; k < 16; k++) b[k*8 +: 8] = 8'(8'h30 + k);
        start_frame(1'b0, b, GAP_A + 3, NB, 1'b1, c);
        wait_cyc(c + 2 + 3*(GAP_A + 3));
        bins_a  = {16{8'hEE}};
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        chk("a_overrun_pulse", {31'd0, ovr_a}, 32'd1);
        @(negedge clk);
        chk("a_overrun_single", {31'd0, ovr_a}, 32'd0);
        d = c + 1 + NB*(GAP_A + 3);
        wait_cyc(d);
        for (int k = 0; k < 16; k++) b[k*8 +: 8] = 8'(8'hF0 - k*8'h05);
        start_frame(1'b0, b, GAP_A + 3, NB, 1'b1, c2);
        chk("a_no_overrun_on_done_cycle", {31'd0, ovr_a}, 32'd0);
        drain(2000);

        // Reset for one cycle right after the 5th byte
        for (int k = 0; k < 16; k++) b[k*8 +: 8] = 8'(8'h61 + k);
        start_frame(1'b0, b, GAP_A + 3, 5, 1'b0, c);
        wait_cyc(c + 2 + 4*(GAP_A + 3));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_done", {31'd0, done_a}, 32'd0);
        chk("midrst_dv", {31'd0, dv_a}, 32'd0);
        chk("midrst_byte", {24'd0, byte_a}, 32'd0);
        repeat (80) @(negedge clk);
        drain(10);

        // All bins 0x10: header build gives A5, sixteen 10s, then 00 (0x100 mod 256)
        start_frame(1'b0, {16{8'h10}}, GAP_A + 3, NB, 1'b1, c);
        drain(2000);

        // GAP_CYCLES=0: strobes every 3 cycles; back-to-back frames leave busy low one cycle
        for (int k = 0; k < 16; k++) b[k*8 +: 8] = 8'(8'hC0 + k);
        start_frame(1'b1, b, 3, NB, 1'b1, c);
        wait_cyc(c + 1 + NB*3);
        start_frame(1'b1, {8{8'h5A, 8'hA5}}, 3, NB, 1'b1, c2);
        drain(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
